// File: rtl/des_sbox_engine_if.sv
// Handshake bundle for des_sbox_engine: 48-bit word in, 32-bit S-box result out.
// The FSM state and chunk counter are also carried here so that monitors can observe them.
interface des_sbox_engine_if;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  dbg_state;
    logic [2:0]  dbg_cnt;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, dbg_state, dbg_cnt
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, dbg_state, dbg_cnt
    );
endinterface

// File: rtl/des_sbox_engine.sv
// Time-multiplexed DES S-box engine: LANES boxes per cycle, 8/LANES cycles per word.
// Optional feature macro DES_SBOX_PERM_EN applies the DES P permutation when out_data is loaded.
module des_sbox_engine #(
    parameter int LANES = 8
) (
    input logic             clk,
    input logic             rst_n,
    des_sbox_engine_if.slave bus
);
    // Both handshakes are valid/ready: a transfer happens on a rising edge where valid and ready are both 1.
    // in_ready combinationally follows out_ready in HOLD, so a new word can enter while the old one leaves.
    localparam int N  = 8 / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
        $error("des_sbox_engine: LANES must be 1, 2, 4 or 8");
    end

    // Each table holds 64 nibbles in row-major order, entry 0 in the top nibble.
    localparam logic [255:0] S1 = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
    localparam logic [255:0] S2 = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
    localparam logic [255:0] S3 = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
    localparam logic [255:0] S4 = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
    localparam logic [255:0] S5 = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
    localparam logic [255:0] S6 = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
    localparam logic [255:0] S7 = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
    localparam logic [255:0] S8 = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;

    function automatic logic [3:0] sbox(input logic [2:0] box, input logic [5:0] a);
        logic [255:0] t;
        int           pos;
        case (box)
            3'd0:    t = S1;
            3'd1:    t = S2;
            3'd2:    t = S3;
            3'd3:    t = S4;
            3'd4:    t = S5;
            3'd5:    t = S6;
            3'd6:    t = S7;
            default: t = S8;
        endcase
        // Row comes from the outer bits, column from the middle four.
        pos = int'({a[5], a[0], a[4:1]});
        return t[255-4*pos -: 4];
    endfunction

`ifdef DES_SBOX_PERM_EN
    localparam int P_TBL [32] = '{16,  7, 20, 21, 29, 12, 28, 17,
                                   1, 15, 23, 26,  5, 18, 31, 10,
                                   2,  8, 24, 14, 32, 27,  3,  9,
                                  19, 13, 30,  6, 22, 11,  4, 25};

    function automatic logic [31:0] finish_word(input logic [31:0] s);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[31-i] = s[32-P_TBL[i]];
        end
        return r;
    endfunction
`else
    function automatic logic [31:0] finish_word(input logic [31:0] s);
        return s;
    endfunction
`endif

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [47:0]   data_q;
    logic [31:0]   res;
    logic [31:0]   out_q;
    logic [31:0]   next_res;
    logic          last;
    logic          accept;
    int            base;

    assign last          = (int'(cnt) == N - 1);
    assign bus.in_ready  = rst_n & ((state == ST_IDLE) | ((state == ST_HOLD) & bus.out_ready));
    assign bus.out_valid = (state == ST_HOLD);
    assign bus.out_data  = out_q;
    assign bus.dbg_state = state;
    assign bus.dbg_cnt   = 3'(cnt);
    assign accept        = bus.in_ready & bus.in_valid;

    always_comb begin
        next_res = res;
        base     = int'(cnt) * LANES;
        for (int l = 0; l < LANES; l++) begin
            next_res[31-4*(base+l) -: 4] = sbox(3'(base + l), data_q[47-6*(base+l) -: 6]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            data_q <= '0;
            res    <= '0;
            out_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        data_q <= bus.in_data;
                        cnt    <= '0;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    res <= next_res;
                    if (last) begin
                        out_q <= finish_word(next_res);
                        cnt   <= '0;
                        state <= ST_HOLD;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        if (accept) begin
                            data_q <= bus.in_data;
                            cnt    <= '0;
                            state  <= ST_RUN;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/des_sbox_engine.md
# des_sbox_engine

Parametrised, handshaked DES substitution engine replacing the per-box combinational S-box lookups in the TDES datapath. It accepts a 48-bit expanded-and-key-mixed word, runs all eight DES S-boxes (S1–S8, FIPS 46-3 tables) over it, and returns the 32-bit result. It time-multiplexes a configurable number of S-box lanes, trading area for latency. It sits between the E-expansion/key-XOR stage and the round XOR in the TDES round logic.

## Interface
- LANES, 8, S-box evaluations per cycle; legal values 1, 2, 4, 8; any other value is an elaboration error.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  engine accepts in_data this cycle.
- in_data  in  48  six-bit chunk i (i=0..7) = in_data[47-6i -: 6] feeds S(i+1).
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  32  S(i+1) nibble at out_data[31-4i -: 4], optionally P-permuted.

## Operation
- S-box addressing per chunk a[5:0]: row = {a[5], a[0]}, column = a[4:1]; all eight standard DES tables.
- N = 8/LANES compute cycles per word.
- FSM states:
  - IDLE: in_ready=1; on in_valid, latch in_data, clear chunk counter, go to RUN.
  - RUN: each cycle evaluate chunks cnt*LANES .. cnt*LANES+LANES-1 into the result register; cnt increments; after the N-th cycle go to HOLD.
  - HOLD: out_valid=1 and out_data stable. On out_ready, go to IDLE, or to RUN if a new word is accepted the same cycle.
- in_ready = IDLE | (HOLD & out_ready). This combinational path from out_ready is intentional.
- Latched input is held until RUN completes. in_data changes after acceptance have no effect.
- The counter is log2(N) bits wide (minimum 1) and wraps to 0 on entry to HOLD.
- LANES=8: RUN lasts one cycle, and the counter is unused but still present.

## Timing
- Reset values: in_ready=0 while rst_n=0, then 1 (IDLE); out_valid=0; out_data=32'h0; cnt=0; FSM=IDLE.
- Latency: input handshake at edge k gives out_valid=1 after edge k+N.
- Throughput: one word per N+1 cycles with out_ready held high.
- Backpressure: out_valid stays high and out_data stays stable in HOLD indefinitely, and in_ready stays 0.
- Simultaneous events: output and input handshakes at the same edge in HOLD give out_valid=0 for the next N cycles, then the new result.
- Reset mid-operation: the in-flight word is discarded, with no output produced. All registers return to reset values at the next edge.
- in_valid while in RUN is ignored, because in_ready=0.

## Configuration
- DES_SBOX_PERM_EN defined: the DES P permutation (32-bit, FIPS 46-3) is applied when loading out_data on entry to HOLD. It adds no cycles.
- DES_SBOX_PERM_EN undefined: out_data is the raw concatenated S-box nibbles. The downstream permutation stays external.

## Test plan
All scenarios run with DES_SBOX_PERM_EN undefined unless noted.
- in_data=48'h0, LANES=8 -> out_data=32'hEFA72C4D, out_valid one cycle after acceptance.
- in_data=48'hFFFFFFFFFFFF, LANES=1 -> out_data=32'hD9CE3DCB, out_valid 8 cycles after acceptance.
- Only chunk 3 = 6'h3F, rest 0, LANES=2 -> out_data=32'hEFAE2C4D (S4 nibble E), latency 4.
- out_ready=0 for 10 cycles after out_valid -> out_valid and out_data held, in_ready=0; release with in_valid=1 -> both handshakes at the same edge, next result N cycles later.
- rst_n=0 for one cycle during RUN (LANES=1, cnt=3) -> out_valid never rises for that word. The next word produces a correct result.
- DES_SBOX_PERM_EN defined, in_data=48'h0 -> out_data equals P(32'hEFA72C4D), checked against the software model.
